// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the UART command parser: ASCII codes of the
// command bytes, FSM state and command encodings, UART timing constant.
package uart_cmd_parser_pkg;

    // One UART bit period at 9600 baud with a 100 MHz clock.
    localparam int UART_BIT_CYC = 10417;

    // Command letters (both cases accepted) and the query byte.
    localparam logic [7:0] ASCII_R_UP  = 8'h52;
    localparam logic [7:0] ASCII_R_LO  = 8'h72;
    localparam logic [7:0] ASCII_D_UP  = 8'h44;
    localparam logic [7:0] ASCII_D_LO  = 8'h64;
    localparam logic [7:0] ASCII_L_UP  = 8'h4C;
    localparam logic [7:0] ASCII_L_LO  = 8'h6C;
    localparam logic [7:0] ASCII_QUERY = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARG_HI,
        ST_ARG_LAST
    } state_t;

    // Which control register a frame in progress targets.
    typedef enum logic [1:0] {
        CMD_RATE,
        CMD_DUTY,
        CMD_LED
    } cmd_t;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte input from the UART receiver plus the parser's control/status outputs.
// master = the side that feeds bytes and watches the results, slave = parser.
interface uart_cmd_parser_if;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [1:0] o_rate;
    logic [7:0] o_duty;
    logic [7:0] o_led;
    logic       o_cmd_ok;
    logic       o_cmd_err;
    logic       o_query;
    logic       o_busy;

    modport master (
        output i_rx_data, i_rx_valid,
        input  o_rate, o_duty, o_led, o_cmd_ok, o_cmd_err, o_query, o_busy
    );

    modport slave (
        input  i_rx_data, i_rx_valid,
        output o_rate, o_duty, o_led, o_cmd_ok, o_cmd_err, o_query, o_busy
    );
endinterface

// File: rtl/uart_cmd_parser_hex_to_nibble.sv
// Combinational ASCII hex digit decoder: '0'-'9', 'A'-'F', 'a'-'f'.
module hex_to_nibble (
    input  logic [7:0] ascii,
    output logic [3:0] nibble,
    output logic       is_hex
);

    // Classify the byte and convert it to its 4-bit value.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs -- no latch.
        nibble = 4'h0;
        is_hex = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nibble = 4'(ascii - 8'h30);
            is_hex = 1'b1;
        end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
            nibble = 4'(ascii - 8'h37);
            is_hex = 1'b1;
        end else if (ascii >= 8'h61 && ascii <= 8'h66) begin
            nibble = 4'(ascii - 8'h57);
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command frame parser behind the UART receiver. Holds the PWM rate,
// PWM duty and LED pattern registers, updating them only on complete valid
// frames, and flags unknown, malformed and timed-out frames.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TIMEOUT_CYC = CLK_HZ / 50,
    parameter int TMO_W       = 21
) (
    input  logic              clk,
    input  logic              reset,
    uart_cmd_parser_if.slave  bus
);

    state_t           state;
    cmd_t             cmd;
    logic [3:0]       hi_nib;
    logic [TMO_W-1:0] tmo_cnt;

    logic [3:0] nibble;
    logic       is_hex;
    logic       tmo_hit;
    logic       arg_ok;

    hex_to_nibble u_hex (
        .ascii  (bus.i_rx_data),
        .nibble (nibble),
        .is_hex (is_hex)
    );

    // Idle time inside a frame is up on this edge unless a byte arrives.
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Final argument digit: any hex digit, except rate which accepts '0'..'3'.
    assign arg_ok = is_hex && ((cmd != CMD_RATE) || (nibble < 4'd4));

    // Frame FSM with timeout counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cmd           <= CMD_RATE;
            hi_nib        <= 4'h0;
            tmo_cnt       <= '0;
            bus.o_rate    <= 2'd0;
            bus.o_duty    <= 8'h00;
            bus.o_led     <= 8'h00;
            bus.o_cmd_ok  <= 1'b0;
            bus.o_cmd_err <= 1'b0;
            bus.o_query   <= 1'b0;
            bus.o_busy    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; pulse defaults below are overridden later in this block.
            bus.o_cmd_ok  <= 1'b0;
            bus.o_cmd_err <= 1'b0;
            bus.o_query   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (bus.i_rx_valid) begin
                        case (bus.i_rx_data)
                            ASCII_R_UP, ASCII_R_LO: begin
                                cmd        <= CMD_RATE;
                                state      <= ST_ARG_LAST;
                                bus.o_busy <= 1'b1;
                            end
                            ASCII_D_UP, ASCII_D_LO: begin
                                cmd        <= CMD_DUTY;
                                state      <= ST_ARG_HI;
                                bus.o_busy <= 1'b1;
                            end
                            ASCII_L_UP, ASCII_L_LO: begin
                                cmd        <= CMD_LED;
                                state      <= ST_ARG_HI;
                                bus.o_busy <= 1'b1;
                            end
                            ASCII_QUERY: bus.o_query   <= 1'b1;
                            default:     bus.o_cmd_err <= 1'b1;
                        endcase
                    end
                end

                ST_ARG_HI, ST_ARG_LAST: begin
                    if (!bus.i_rx_valid) begin
                        // No byte this cycle: advance the inter-byte timer.
                        if (tmo_hit) begin
                            tmo_cnt       <= '0;
                            state         <= ST_IDLE;
                            bus.o_busy    <= 1'b0;
                            bus.o_cmd_err <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end else if (state == ST_ARG_HI) begin
                        tmo_cnt <= '0;
                        if (is_hex) begin
                            hi_nib <= nibble;
                            state  <= ST_ARG_LAST;
                        end else begin
                            state         <= ST_IDLE;
                            bus.o_busy    <= 1'b0;
                            bus.o_cmd_err <= 1'b1;
                        end
                    end else begin
                        tmo_cnt    <= '0;
                        state      <= ST_IDLE;
                        bus.o_busy <= 1'b0;
                        if (arg_ok) begin
                            bus.o_cmd_ok <= 1'b1;
                            case (cmd)
                                CMD_RATE: bus.o_rate <= nibble[1:0];
                                CMD_DUTY: bus.o_duty <= {hi_nib, nibble};
                                default:  bus.o_led  <= {hi_nib, nibble};
                            endcase
                        end else begin
                            bus.o_cmd_err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    bus.o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames plus randomized
// byte streams, all compared every cycle against a frame-level model.
module tb_uart_cmd_parser;

    localparam int TMO = 50;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .CLK_HZ      (100_000_000),
        .TIMEOUT_CYC (TMO),
        .TMO_W       (21)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bytes of the frame collected so far, plus registers.
    logic [7:0] frame[$];
    int         gap;
    logic [1:0] m_rate;
    logic [7:0] m_duty, m_led;
    logic       m_ok, m_err, m_query;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] upcase(input logic [7:0] c);
        if (c >= "a" && c <= "z") return c - 8'd32;
        return c;
    endfunction

    task automatic model_reset();
        frame.delete();
        gap     = 0;
        m_rate  = 2'd0;
        m_duty  = 8'h00;
        m_led   = 8'h00;
        m_ok    = 1'b0;
        m_err   = 1'b0;
        m_query = 1'b0;
    endtask

    // A byte arrives: extend the frame and judge it by the command grammar.
    task automatic model_byte(input logic [7:0] c);
        logic [7:0] letter;
        int v;
        m_ok = 1'b0; m_err = 1'b0; m_query = 1'b0;
        gap = 0;
        frame.push_back(c);
        letter = upcase(frame[0]);
        v = hexval(c);
        if (frame.size() == 1) begin
            if (c == "?") begin
                m_query = 1'b1;
                frame.delete();
            end else if (!(letter inside {"R", "D", "L"})) begin
                m_err = 1'b1;
                frame.delete();
            end
        end else if (v < 0 || (letter == "R" && v > 3)) begin
            m_err = 1'b1;
            frame.delete();
        end else if (letter == "R") begin
            m_rate = 2'(v);
            m_ok = 1'b1;
            frame.delete();
        end else if (frame.size() == 3) begin
            v = hexval(frame[1]) * 16 + v;
            if (letter == "D") m_duty = 8'(v);
            else               m_led  = 8'(v);
            m_ok = 1'b1;
            frame.delete();
        end
    endtask

    // A cycle with no byte: an open frame ages and dies after TMO cycles.
    task automatic model_idle();
        m_ok = 1'b0; m_err = 1'b0; m_query = 1'b0;
        if (frame.size() != 0) begin
            gap++;
            if (gap == TMO) begin
                m_err = 1'b1;
                frame.delete();
                gap = 0;
            end
        end
    endtask

    // One clock: drive the byte, let the edge happen, compare everything.
    task automatic step(input logic v, input logic [7:0] d);
        @(negedge clk);
        bus.i_rx_valid = v;
        bus.i_rx_data  = d;
        @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
        if (v) model_byte(d);
        else   model_idle();
        check("cycle",
              {10'd0, bus.o_rate, bus.o_duty, bus.o_led,
               bus.o_cmd_ok, bus.o_cmd_err, bus.o_query, bus.o_busy},
              {10'd0, m_rate, m_duty, m_led,
               m_ok, m_err, m_query, (frame.size() != 0)});
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d);
        step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        model_reset();
        check("rst_regs", {14'd0, bus.o_rate, bus.o_duty, bus.o_led}, 32'd0);
        check("rst_flags", {28'd0, bus.o_cmd_ok, bus.o_cmd_err, bus.o_query, bus.o_busy}, 32'd0);
        reset = 1'b1;
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] letters [6] = '{"R", "r", "D", "d", "L", "l"};
        logic [7:0] hexes [16]  = '{"0", "1", "2", "3", "4", "5", "6", "7",
                                    "8", "9", "A", "f", "B", "e", "c", "D"};
        case ($urandom_range(0, 9))
            0, 1, 2:       return letters[$urandom_range(0, 5)];
            3:             return "?";
            4, 5, 6, 7:    return hexes[$urandom_range(0, 15)];
            8:             return "G";
            default:       return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idle_pulses;
        int k;
        logic [7:0] e2e [6] = '{8'h34, 8'h4D, 8'h35, 8'h46, 8'h34, 8'h3F};

        reset = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        model_reset();
        do_reset();

        // Reset in the middle of a frame, then a quiet line.
        step(1'b1, "D");
        step(1'b1, "5");
        check("busy_mid", 32'(bus.o_busy), 32'd1);
        do_reset();
        idle_pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 8'h00);
            idle_pulses += int'(bus.o_cmd_ok) + int'(bus.o_cmd_err) + int'(bus.o_query) + int'(bus.o_busy);
        end
        check("idle_pulses", 32'(idle_pulses), 32'd0);

        // Rate frames, both letter cases.
        step(1'b1, "R");
        check("busy_after_r", 32'(bus.o_busy), 32'd1);
        step(1'b1, "2");
        check("ok_r2", 32'(bus.o_cmd_ok), 32'd1);
        check("rate_r2", 32'(bus.o_rate), 32'd2);
        step(1'b0, 8'h00);
        check("ok_one_cycle", 32'(bus.o_cmd_ok), 32'd0);
        send("r"); send("3");
        check("rate_r3", 32'(bus.o_rate), 32'd3);

        // Duty and LED frames, busy between bytes.
        send("D");
        check("busy_d1", 32'(bus.o_busy), 32'd1);
        send("8");
        check("busy_d2", 32'(bus.o_busy), 32'd1);
        send("0");
        check("duty_80", 32'(bus.o_duty), 32'h80);
        send("L"); send("a");
        step(1'b1, "5");
        check("led_a5", 32'(bus.o_led), 32'hA5);
        check("busy_end", 32'(bus.o_busy), 32'd0);

        // Bad digits leave registers alone; the parser recovers.
        send("R");
        step(1'b1, "5");
        check("err_r5", 32'(bus.o_cmd_err), 32'd1);
        check("rate_kept", 32'(bus.o_rate), 32'd3);
        send("D");
        step(1'b1, "G");
        check("err_dg", 32'(bus.o_cmd_err), 32'd1);
        check("idle_dg", 32'(bus.o_busy), 32'd0);
        send("R"); send("1");
        check("rate_r1", 32'(bus.o_rate), 32'd1);

        // Timeout: error exactly TMO cycles after the last byte.
        step(1'b1, "D");
        step(1'b1, "4");
        k = 0;
        for (int i = 1; i <= 2 * TMO && k == 0; i++) begin
            step(1'b0, 8'h00);
            if (bus.o_cmd_err) k = i;
        end
        check("tmo_cycles", 32'(k), 32'(TMO));
        check("tmo_duty", 32'(bus.o_duty), 32'h80);

        // A byte on the expiry cycle completes the frame instead.
        step(1'b1, "D");
        step(1'b1, "4");
        repeat (TMO - 1) step(1'b0, 8'h00);
        step(1'b1, "2");
        check("expiry_ok", 32'(bus.o_cmd_ok), 32'd1);
        check("expiry_duty", 32'(bus.o_duty), 32'h42);

        // Byte stream as the UART would deliver it, spaced out.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, e2e[i]);
            check("e2e_err", 32'(bus.o_cmd_err), (i < 5) ? 32'd1 : 32'd0);
            check("e2e_query", 32'(bus.o_query), (i == 5) ? 32'd1 : 32'd0);
            repeat (20) step(1'b0, 8'h00);
        end
        check("e2e_regs", {14'd0, bus.o_rate, bus.o_duty, bus.o_led}, {14'd0, 2'd1, 8'h42, 8'hA5});

        // Randomized byte streams with occasional long gaps and resets.
        for (int n = 0; n < 3000; n++) begin
            int g;
            if ($urandom_range(0, 299) == 0) do_reset();
            step(1'b1, pick_byte());
            g = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TMO - 5, TMO + 5))
                                             : int'($urandom_range(0, 3));
            repeat (g) step(1'b0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
